// File: rtl/counter_ctrl.sv
// Interval-timer sequencer for an external up-counter: load, count to period-1,
// flag expiry, optionally auto-reload, and keep a saturating expiry tally.
module counter_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TALLY_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   period,
    input  logic               auto_reload,
    input  logic [WIDTH-1:0]   cnt_value,
    output logic               cnt_load,
    output logic [WIDTH-1:0]   cnt_init,
    output logic               cnt_en,
    output logic               busy,
    output logic               done,
    output logic               start_err,
    output logic [TALLY_W-1:0] expire_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     period_q, period_d;
    logic                 reload_q, reload_d;
    logic [TALLY_W-1:0]   tally_q, tally_d;
    logic                 err_d;
    logic                 done_q, err_q, load_q;
    logic                 terminal;

    // The counter starts from 0, so the last RUN cycle sees period_q-1.
    assign terminal = (cnt_value == period_q - WIDTH'(1));

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        reload_d = reload_q;
        tally_d  = tally_q;
        err_d    = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (period != '0) begin
                        state_d  = LOAD;
                        period_d = period;
                        reload_d = auto_reload;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: state_d = stop ? IDLE : RUN;
            RUN: begin
                cnt_en = ~terminal & ~stop;
                if (stop)          state_d = IDLE;
                else if (terminal) state_d = DONE;
            end
            DONE: begin
                if (tally_q != '1) tally_d = tally_q + TALLY_W'(1);
                // stop outranks reload, but the expiry itself still counts
                if (stop)          state_d = IDLE;
                else if (reload_q) state_d = LOAD;
                else               state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            reload_q <= 1'b0;
            tally_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            reload_q <= reload_d;
            tally_q  <= tally_d;
            done_q   <= (state_d == DONE);
            err_q    <= err_d;
            load_q   <= (state_d == LOAD);
        end
    end

    assign cnt_load     = load_q;
    assign cnt_init     = '0;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign start_err    = err_q;
    assign expire_count = tally_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: a cycle model pushes expected registered outputs
// into a scoreboard queue; they are popped and compared after each clock edge.
module tb_counter_ctrl;
    localparam int W = 32;

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_RUN  = 2;
    localparam int S_DONE = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0, start = 1'b0, stop = 1'b0, auto_reload = 1'b0;
    logic [W-1:0] period = '0;
    logic [W-1:0] cnt_value = '0;

    logic         cnt_load, cnt_en, busy, done, start_err;
    logic [W-1:0] cnt_init;
    logic [15:0]  expire_count;
    logic         b_cnt_load, b_cnt_en, b_busy, b_done, b_start_err;
    logic [W-1:0] b_cnt_init;
    logic [1:0]   b_expire_count;

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(W), .TALLY_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .period(period),
        .auto_reload(auto_reload), .cnt_value(cnt_value), .cnt_load(cnt_load),
        .cnt_init(cnt_init), .cnt_en(cnt_en), .busy(busy), .done(done),
        .start_err(start_err), .expire_count(expire_count)
    );

    counter_ctrl #(.WIDTH(W), .TALLY_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .period(period),
        .auto_reload(auto_reload), .cnt_value(cnt_value), .cnt_load(b_cnt_load),
        .cnt_init(b_cnt_init), .cnt_en(b_cnt_en), .busy(b_busy), .done(b_done),
        .start_err(b_start_err), .expire_count(b_expire_count)
    );

    // Counter datapath being sequenced
    always @(posedge clk) begin
        if (cnt_load)    cnt_value <= cnt_init;
        else if (cnt_en) cnt_value <= cnt_value + 1;
    end

    typedef struct {
        logic busy;
        logic done;
        logic err;
        logic load;
        int   tally;
        int   tally2;
    } exp_t;

    exp_t sb[$];

    int          n_tests = 0, n_fail = 0;
    int          m_st = S_IDLE, m_cnt = 0, m_tally = 0;
    int          m_per = 0;
    logic        m_rl = 1'b0;
    int          cyc = 0, n_done = 0, n_en = 0, load_cyc = -1, max_cnt = 0;
    int          done_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_done = 0; n_en = 0; load_cyc = -1; max_cnt = 0;
        done_cyc.delete();
    endtask

    task automatic cycle(input logic r, input logic s, input logic sp,
                         input logic [31:0] per, input logic ar);
        exp_t e;
        int   ns;
        logic en;
        rst = r; start = s; stop = sp; period = per; auto_reload = ar;
        #1;
        en = (m_st == S_RUN) && (m_cnt != m_per - 1) && !sp;
        if (!r) begin
            chk("cnt_en", {31'b0, cnt_en}, {31'b0, en});
            chk("cnt_en_sat", {31'b0, b_cnt_en}, {31'b0, en});
        end
        if (cnt_en === 1'b1) n_en++;
        if (int'(cnt_value) > max_cnt) max_cnt = int'(cnt_value);
        e.err = 1'b0;
        ns = m_st;
        if (r) begin
            ns = S_IDLE; m_per = 0; m_rl = 1'b0; m_tally = 0;
        end else begin
            case (m_st)
                S_IDLE: if (s) begin
                    if (per != 0) begin ns = S_LOAD; m_per = int'(per); m_rl = ar; end
                    else e.err = 1'b1;
                end
                S_LOAD: begin ns = sp ? S_IDLE : S_RUN; m_cnt = 0; end
                S_RUN: begin
                    if (sp)                     ns = S_IDLE;
                    else if (m_cnt == m_per-1)  ns = S_DONE;
                    else                        m_cnt++;
                end
                default: begin
                    m_tally++;
                    ns = (sp || !m_rl) ? S_IDLE : S_LOAD;
                end
            endcase
        end
        e.busy   = (ns != S_IDLE);
        e.done   = (ns == S_DONE);
        e.load   = (ns == S_LOAD);
        e.tally  = (m_tally > 65535) ? 65535 : m_tally;
        e.tally2 = (m_tally > 3) ? 3 : m_tally;
        m_st = ns;
        sb.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        chk("busy",         {31'b0, busy},      {31'b0, e.busy});
        chk("done",         {31'b0, done},      {31'b0, e.done});
        chk("start_err",    {31'b0, start_err}, {31'b0, e.err});
        chk("cnt_load",     {31'b0, cnt_load},  {31'b0, e.load});
        chk("expire_count", {16'b0, expire_count}, e.tally);
        chk("busy_sat",     {31'b0, b_busy},    {31'b0, e.busy});
        chk("done_sat",     {31'b0, b_done},    {31'b0, e.done});
        chk("expire_sat",   {30'b0, b_expire_count}, e.tally2);
        if (done === 1'b1) begin n_done++; done_cyc.push_back(cyc); end
        if (cnt_load === 1'b1) load_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        int s0;

        // T1 reset
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("cnt_init", cnt_init, 32'd0);
        idle(1);

        // T2 one-shot, period 5
        clear_stats();
        cycle(1'b0, 1'b1, 1'b0, 32'd5, 1'b0);
        idle(9);
        chk("t2_done_count", n_done, 1);
        chk("t2_en_cycles", n_en, 4);
        chk("t2_max_cnt", max_cnt, 4);
        if (done_cyc.size() > 0) chk("t2_load_to_done", done_cyc[0] - load_cyc, 6);
        chk("t2_tally", {16'b0, expire_count}, 1);

        // T3 auto-reload, period 3, stop after third done
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        clear_stats();
        cycle(1'b0, 1'b1, 1'b0, 32'd3, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (n_done >= 3) break;
            idle(1);
        end
        cycle(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
        idle(8);
        chk("t3_done_count", n_done, 3);
        if (done_cyc.size() >= 3) begin
            chk("t3_gap1", done_cyc[1] - done_cyc[0], 5);
            chk("t3_gap2", done_cyc[2] - done_cyc[1], 5);
        end
        chk("t3_tally", {16'b0, expire_count}, 3);

        // T4 period 1, then period 0
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        clear_stats();
        s0 = cyc;
        cycle(1'b0, 1'b1, 1'b0, 32'd1, 1'b0);
        idle(5);
        chk("t4_en_cycles", n_en, 0);
        chk("t4_done_count", n_done, 1);
        if (done_cyc.size() > 0) chk("t4_start_to_done", done_cyc[0] - s0, 3);
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        idle(2);

        // T5 abort mid-run; start/period change while busy ignored
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 32'd2, 1'b0);
        idle(6);
        clear_stats();
        cycle(1'b0, 1'b1, 1'b0, 32'd10, 1'b0);
        idle(2);
        cycle(1'b0, 1'b1, 1'b0, 32'd2, 1'b1);
        idle(1);
        cycle(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
        idle(12);
        chk("t5_done_count", n_done, 0);
        chk("t5_tally", {16'b0, expire_count}, 1);

        // T6 saturation on the 2-bit tally, then reset mid-run
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        clear_stats();
        cycle(1'b0, 1'b1, 1'b0, 32'd2, 1'b1);
        for (int i = 0; i < 60; i++) begin
            if (n_done >= 6) break;
            idle(1);
        end
        chk("t6_done_count", n_done, 6);
        chk("t6_tally_sat", {30'b0, b_expire_count}, 3);
        idle(8);
        chk("t6_tally_hold", {30'b0, b_expire_count}, 3);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
